// File: rtl/biss_frame_decoder.sv
// Passive BiSS-C frame monitor: decodes position, nE/nW and CRC6 from SCK/SLO,
// checks the CRC and reports framing errors and SCK stalls.
module biss_frame_decoder #(
    parameter int unsigned MAX_BITS     = 64,
    parameter logic [5:0]  CRC_POLY     = 6'h03,
    parameter int unsigned STALL_CYCLES = 2500,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                ssi_sck_i,
    input  logic                ssi_dat_i,
    input  logic [7:0]          BITS,
    output logic                result_valid,
    output logic [MAX_BITS-1:0] data_result,
    output logic [1:0]          nEnW_data,
    output logic [5:0]          CRC_data,
    output logic                crc_err,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);
    localparam int unsigned WD_W  = $clog2(STALL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ACK, S_CDS, S_DATA, S_NENW, S_CRC, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [SYNC_STAGES-1:0] sck_sync, dat_sync;
    logic                sck_prev;
    logic                sck_s, dat_s, sck_rise, sck_fall;

    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0]    bits_q, bits_n, bits_clamp;
    logic [WD_W-1:0]     wd, wd_n;
    logic [5:0]          crc, crc_n, crc_step;
    logic [5:0]          crc_rx, crc_rx_n;
    logic [1:0]          nenw, nenw_n;
    logic [MAX_BITS-1:0] shreg, shreg_n;
    logic                in_frame, stall, frame_err_n, busy_n;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    // Synchronisers preset to the idle-high line level so reset release makes no edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sck_sync <= '1;
            dat_sync <= '1;
            sck_prev <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], ssi_sck_i};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ssi_dat_i};
            sck_prev <= sck_s;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bits_n      = bits_q;
        crc_n       = crc;
        crc_rx_n    = crc_rx;
        nenw_n      = nenw;
        shreg_n     = shreg;
        wd_n        = '0;
        frame_err_n = 1'b0;
        crc_step    = {crc[4:0], 1'b0} ^ ((crc[5] ^ dat_s) ? CRC_POLY : 6'h00);

        if (BITS == 8'd0)                 bits_clamp = CNT_W'(1);
        else if (32'(BITS) > MAX_BITS)    bits_clamp = CNT_W'(MAX_BITS);
        else                              bits_clamp = CNT_W'(BITS);

        // Watchdog runs from ACK through CRC and restarts on every SCK rise
        in_frame = (state inside {S_ACK, S_CDS, S_DATA, S_NENW, S_CRC});
        if (in_frame && !sck_rise) wd_n = wd + WD_W'(1);
        stall = in_frame && !sck_rise && (wd == WD_W'(STALL_CYCLES - 1));

        case (state)
            S_IDLE: if (sck_s && dat_s) state_n = S_ARM;
            S_ARM: begin
                if (sck_fall) begin
                    state_n = S_ACK;
                    bits_n  = bits_clamp;
                end
            end
            S_ACK: if (sck_rise && dat_s) state_n = S_CDS;
            S_CDS: begin
                if (sck_rise) begin
                    if (dat_s) begin
                        frame_err_n = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        crc_n   = '0;
                        cnt_n   = '0;
                        shreg_n = '0;
                    end
                end
            end
            S_DATA: begin
                if (sck_rise) begin
                    shreg_n = {shreg[MAX_BITS-2:0], dat_s};
                    crc_n   = crc_step;
                    if (cnt == bits_q - CNT_W'(1)) begin
                        state_n = S_NENW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_NENW: begin
                if (sck_rise) begin
                    nenw_n = {nenw[0], dat_s};
                    crc_n  = crc_step;
                    if (cnt == CNT_W'(1)) begin
                        state_n = S_CRC;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_CRC: begin
                if (sck_rise) begin
                    crc_rx_n = {crc_rx[4:0], dat_s};
                    if (cnt == CNT_W'(5)) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (stall) begin
            state_n     = S_IDLE;
            frame_err_n = 1'b1;
        end

        busy_n = (state_n inside {S_ACK, S_CDS, S_DATA, S_NENW, S_CRC, S_DONE});
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt          <= '0;
            bits_q       <= '0;
            wd           <= '0;
            crc          <= '0;
            crc_rx       <= '0;
            nenw         <= '0;
            shreg        <= '0;
            result_valid <= 1'b0;
            data_result  <= '0;
            nEnW_data    <= '0;
            CRC_data     <= '0;
            crc_err      <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            bits_q       <= bits_n;
            wd           <= wd_n;
            crc          <= crc_n;
            crc_rx       <= crc_rx_n;
            nenw         <= nenw_n;
            shreg        <= shreg_n;
            result_valid <= (state == S_DONE);
            frame_err    <= frame_err_n;
            busy         <= busy_n;
            if (state == S_DONE) begin
                data_result <= shreg;
                nEnW_data   <= nenw;
                CRC_data    <= crc_rx;
                crc_err     <= (crc_rx != ~crc);
            end
        end
    end

endmodule

// File: tb/tb_biss_frame_decoder.sv
// Scoreboard bench for biss_frame_decoder: drives BiSS-C frames on SCK/SLO and
// compares every result_valid against the expected frame queued at drive time.
module tb_biss_frame_decoder;

    localparam int unsigned MAX_BITS = 64;
    localparam int unsigned STALL    = 2500;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                sck, dat;
    logic [7:0]          bits;
    logic                result_valid;
    logic [MAX_BITS-1:0] data_result;
    logic [1:0]          nEnW_data;
    logic [5:0]          CRC_data;
    logic                crc_err, frame_err, busy;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  nenw;
        logic [5:0]  crc;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   n_chk = 0, n_bad = 0, n_rv = 0, n_fe = 0;

    biss_frame_decoder #(
        .MAX_BITS(MAX_BITS), .CRC_POLY(6'h03), .STALL_CYCLES(STALL), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ssi_sck_i(sck), .ssi_dat_i(dat), .BITS(bits),
        .result_valid(result_valid), .data_result(data_result), .nEnW_data(nEnW_data),
        .CRC_data(CRC_data), .crc_err(crc_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // x^6 + x + 1 long division over data (MSB first) then nE, nW
    function automatic logic [5:0] crc_calc(input logic [63:0] d, input int n, input logic [1:0] ne);
        logic [5:0] c = '0;
        logic       b;
        for (int i = n + 1; i >= 0; i--) begin
            b = (i >= 2) ? d[i-2] : ne[i];
            if (c[5] ^ b) c = {c[4:0], 1'b0} ^ 6'b000011;
            else          c = {c[4:0], 1'b0};
        end
        return c;
    endfunction

    always @(negedge clk_i) begin
        if (frame_err) n_fe++;
        if (result_valid) begin
            n_rv++;
            if (sb_q.size() == 0) begin
                check("unexpected_rv", 64'd1, 64'd0);
            end else begin
                e_mon = sb_q.pop_front();
                check("data_result", data_result, e_mon.data);
                check("nEnW_data", 64'(nEnW_data), 64'(e_mon.nenw));
                check("CRC_data", 64'(CRC_data), 64'(e_mon.crc));
                check("crc_err", 64'(crc_err), 64'(e_mon.err));
            end
        end
    end

    task automatic sck_bit(input logic d);
        @(negedge clk_i); sck = 1'b0; dat = d;
        repeat (4) @(negedge clk_i);
        sck = 1'b1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic line_idle(input int n);
        @(negedge clk_i); sck = 1'b1; dat = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    // mode: 0 good, 1 CRC bit flipped, 2 CDS high, 3 stall after 10 data bits, 4 reset after 10 data bits
    task automatic send_frame(input int bits_val, input logic [63:0] data, input logic [1:0] ne, input int mode);
        int         n;
        int         fe0;
        logic [5:0] wcrc;
        n    = (bits_val == 0) ? 1 : ((bits_val > 64) ? 64 : bits_val);
        wcrc = ~crc_calc(data, n, ne);
        if (mode == 1) wcrc[2] = ~wcrc[2];
        bits = 8'(bits_val);
        line_idle(20);
        if (mode <= 1) sb_q.push_back('{data: data, nenw: ne, crc: wcrc, err: (mode == 1)});
        sck_bit(1'b0);
        sck_bit(1'b0);
        sck_bit(1'b1);
        sck_bit(mode == 2);
        if (mode == 2) begin
            line_idle(10);
            check("busy_after_cds_err", 64'(busy), 64'd0);
            return;
        end
        for (int i = n - 1; i >= 0; i--) begin
            sck_bit(data[i]);
            if (mode >= 3 && i == n - 10) begin
                check("busy_mid_frame", 64'(busy), 64'd1);
                if (mode == 3) begin
                    fe0 = n_fe;
                    repeat (STALL - 20) @(negedge clk_i);
                    check("no_early_stall", 64'(n_fe), 64'(fe0));
                    repeat (30) @(negedge clk_i);
                    check("stall_frame_err", 64'(n_fe), 64'(fe0 + 1));
                    check("busy_after_stall", 64'(busy), 64'd0);
                end else begin
                    @(negedge clk_i); reset_i = 1'b1;
                    repeat (3) @(negedge clk_i);
                    check("rst_busy", 64'(busy), 64'd0);
                    check("rst_data", data_result, 64'd0);
                    reset_i = 1'b0;
                end
                line_idle(10);
                return;
            end
        end
        sck_bit(ne[1]);
        sck_bit(ne[0]);
        for (int i = 5; i >= 0; i--) sck_bit(wcrc[i]);
        line_idle(2);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk_i);
        check("rv_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int rv0;
        reset_i = 1'b1; sck = 1'b1; dat = 1'b1; bits = 8'd32;
        repeat (5) @(negedge clk_i);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_data_result", data_result, 64'd0);
        check("rst_nEnW", 64'(nEnW_data), 64'd0);
        check("rst_CRC", 64'(CRC_data), 64'd0);
        check("rst_crc_err", 64'(crc_err), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_i = 1'b0;

        send_frame(32, 64'h0000_0000_DEAD_BEEF, 2'b11, 0);
        send_frame(32, 64'h0000_0000_DEAD_BEEF, 2'b11, 1);
        send_frame(64, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0);
        send_frame(1,  64'h1, 2'b10, 0);
        send_frame(0,  64'h1, 2'b01, 0);
        send_frame(200, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
        send_frame(32, 64'h0000_0000_1234_5678, 2'b11, 2);
        send_frame(32, 64'h0000_0000_1234_5678, 2'b01, 0);
        send_frame(32, 64'h0000_0000_CAFE_F00D, 2'b11, 3);
        send_frame(32, 64'h0000_0000_5555_AAAA, 2'b11, 4);
        rv0 = n_rv;
        send_frame(24, 64'h0000_0000_00AB_CDEF, 2'b11, 0);
        line_idle(20);
        check("rv_after_reset", 64'(n_rv - rv0), 64'd1);
        check("rv_total", 64'(n_rv), 64'd8);
        check("fe_total", 64'(n_fe), 64'd2);
        check("queue_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
